launch_arbiter: RTL and testbench

LAUNCH_ARBITER -- requirements
Module: launch_arbiter

---
 rtl/launch_arbiter.sv | 169 ++++++++++++++++
 tb/tb_launch_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/launch_arbiter.sv
// launch_arbiter: round-robin grant of three rocket launchers driven by sector
// radars, with per-launcher ammunition counters, reload handling, a post-launch
// cooldown and a sticky fault flag on a missing fire acknowledge.
module launch_arbiter #(
    parameter int MAX_AMMO    = 29,
    parameter int COOLDOWN    = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       radar_1,
    input  logic       radar_2,
    input  logic       radar_3,
    input  logic       reload_en,
    input  logic [1:0] reload_sel,
    input  logic [4:0] reload_value,
    input  logic       fire_ack,
    output logic       fire_req,
    output logic [1:0] fire_sel,
    output logic [4:0] ammunition_1,
    output logic [4:0] ammunition_2,
    output logic [4:0] ammunition_3,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    localparam logic [5:0] MAX_AMMO_6 = 6'(MAX_AMMO);
    localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(ACK_TIMEOUT - 1);

    state_t         state;
    state_t         state_next;
    logic [3:1][4:0] ammo;
    logic [1:0]     last_grant;
    logic [7:0]     wait_cnt;
    logic [7:0]     cool_cnt;

    logic [3:1]     eligible;
    logic           reload_accept;
    logic [1:0]     pick;
    logic           launch_done;
    logic           ack_timeout;

    // Saturating add through a 6-bit intermediate so 31+31 cannot wrap.
    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > MAX_AMMO_6) ? MAX_AMMO_6[4:0] : sum[4:0];
    endfunction

    assign ammunition_1 = ammo[1];
    assign ammunition_2 = ammo[2];
    assign ammunition_3 = ammo[3];

    assign eligible[1] = radar_1 && (ammo[1] != 5'd0);
    assign eligible[2] = radar_2 && (ammo[2] != 5'd0);
    assign eligible[3] = radar_3 && (ammo[3] != 5'd0);

    assign reload_accept = (state == IDLE) && reload_en && (reload_sel != 2'd0);

    // Round-robin pick: scan the launchers starting after the last one granted.
    always_comb begin
        logic [1:0] cand;
        // NOTE: every comb output gets a default before any branch, so no latch is inferred.
        pick = 2'd0;
        cand = last_grant;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
            if (pick == 2'd0 && eligible[cand]) begin
                pick = cand;
            end
        end
    end

    // Next-state logic and the launch / timeout events.
    always_comb begin
        state_next  = state;
        launch_done = 1'b0;
        ack_timeout = 1'b0;
        case (state)
            IDLE: begin
                // A reload in the same cycle wins; arbitration retries with the new counts.
                if (!reload_accept && pick != 2'd0) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (fire_ack) begin
                    launch_done = 1'b1;
                    state_next  = COOL;
                end else if (wait_cnt == WAIT_LAST) begin
                    ack_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            COOL: begin
                if (cool_cnt == COOL_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, registered outputs, round-robin pointer and cycle counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fire_req   <= 1'b0;
            fire_sel   <= 2'd0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            last_grant <= 2'd3;
            wait_cnt   <= 8'd0;
            cool_cnt   <= 8'd0;
        end else begin
            // NOTE: state and counters use non-blocking assignments so every flop sees pre-edge values.
            state    <= state_next;
            fire_req <= (state_next == GRANT);
            busy     <= (state_next != IDLE);
            fault    <= fault | ack_timeout;

            // fire_sel is also the granted index; it is held for the whole GRANT stay.
            if (state == IDLE && state_next == GRANT) begin
                fire_sel <= pick;
            end else if (state_next != GRANT) begin
                fire_sel <= 2'd0;
            end

            if (launch_done || ack_timeout) begin
                last_grant <= fire_sel;
            end

            if (state == GRANT && !fire_ack && !ack_timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end

            if (state == COOL && state_next == COOL) begin
                cool_cnt <= cool_cnt + 8'd1;
            end else begin
                cool_cnt <= 8'd0;
            end
        end
    end

    // Ammunition counters: saturating reload in IDLE, single decrement on an acked launch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ammo <= '0;
        end else begin
            for (int n = 1; n <= 3; n++) begin
                if (reload_accept && reload_sel == 2'(n)) begin
                    ammo[n] <= sat_add(ammo[n], reload_value);
                end else if (launch_done && fire_sel == 2'(n) && ammo[n] != 5'd0) begin
                    ammo[n] <= ammo[n] - 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_launch_arbiter.sv
// Directed bench for launch_arbiter with default parameters
// (MAX_AMMO=29, COOLDOWN=8, ACK_TIMEOUT=16).
module tb_launch_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       radar_1, radar_2, radar_3;
    logic       reload_en;
    logic [1:0] reload_sel;
    logic [4:0] reload_value;
    logic       fire_ack;
    logic       fire_req;
    logic [1:0] fire_sel;
    logic [4:0] ammunition_1, ammunition_2, ammunition_3;
    logic       busy;
    logic       fault;

    int vectors     = 0;
    int miscompares = 0;

    launch_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .radar_1      (radar_1),
        .radar_2      (radar_2),
        .radar_3      (radar_3),
        .reload_en    (reload_en),
        .reload_sel   (reload_sel),
        .reload_value (reload_value),
        .fire_ack     (fire_ack),
        .fire_req     (fire_req),
        .fire_sel     (fire_sel),
        .ammunition_1 (ammunition_1),
        .ammunition_2 (ammunition_2),
        .ammunition_3 (ammunition_3),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expected, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reload(input logic [1:0] sel, input logic [4:0] val);
        reload_en    = 1'b1;
        reload_sel   = sel;
        reload_value = val;
        tick();
        reload_en    = 1'b0;
        reload_sel   = 2'd0;
        reload_value = 5'd0;
    endtask

    task automatic ack_once();
        fire_ack = 1'b1;
        tick();
        fire_ack = 1'b0;
    endtask

    // Ticks until fire_req rises; n returns the number of edges taken (max if never).
    task automatic wait_fire(input int max, output int n);
        n = 0;
        while (!fire_req && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 64) begin
            tick();
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic check_ammo(input string tag, input int a1, input int a2, input int a3);
        check({tag, "_a1"}, ammunition_1, a1);
        check({tag, "_a2"}, ammunition_2, a2);
        check({tag, "_a3"}, ammunition_3, a3);
    endtask

    initial begin
        int n;
        int exp_a [1:3];
        int exp_sel;
        int fires;

        reset_n      = 1'b0;
        radar_1      = 1'b0;
        radar_2      = 1'b0;
        radar_3      = 1'b0;
        reload_en    = 1'b0;
        reload_sel   = 2'd0;
        reload_value = 5'd0;
        fire_ack     = 1'b0;

        // Reset values, still held after release until the first edge.
        #12;
        check("rst_fire_req", fire_req, 0);
        check("rst_fire_sel", fire_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check_ammo("rst", 0, 0, 0);
        #11 reset_n = 1'b1;
        #1;
        check("rel_fire_req", fire_req, 0);
        check("rel_busy", busy, 0);
        tick();

        // Reload 1<-10, 2<-5, 3<-0; then all radars -> 1,2,1,2 with launcher 3 empty.
        do_reload(2'd1, 5'd10);
        do_reload(2'd2, 5'd5);
        do_reload(2'd3, 5'd0);
        check_ammo("reload", 10, 5, 0);
        exp_a[1] = 10; exp_a[2] = 5; exp_a[3] = 0;

        radar_1 = 1'b1; radar_2 = 1'b1; radar_3 = 1'b1;
        tick();
        check("first_grant_req", fire_req, 1);
        for (int i = 0; i < 4; i++) begin
            exp_sel = (i % 2 == 0) ? 1 : 2;
            if (i > 0) begin
                wait_fire(64, n);
                check("cool_latency", n, 9);
            end
            check("rr_sel", fire_sel, exp_sel);
            check("rr_busy", busy, 1);
            ack_once();
            exp_a[exp_sel]--;
            check("after_ack_req", fire_req, 0);
            check_ammo("rr", exp_a[1], exp_a[2], exp_a[3]);
        end
        // Now in COOL: reload must be dropped.
        radar_1 = 1'b0; radar_2 = 1'b0; radar_3 = 1'b0;
        do_reload(2'd1, 5'd5);
        check_ammo("cool_reload", 8, 3, 0);
        wait_idle();

        // Reload and radar in the same IDLE cycle: reload first, grant one edge later.
        reload_en = 1'b1; reload_sel = 2'd3; reload_value = 5'd2;
        radar_1 = 1'b1;
        tick();
        reload_en = 1'b0; reload_sel = 2'd0; reload_value = 5'd0;
        check_ammo("prio_reload", 8, 3, 2);
        check("prio_no_req", fire_req, 0);
        tick();
        check("prio_req", fire_req, 1);
        check("prio_sel", fire_sel, 1);
        ack_once();
        radar_1 = 1'b0;
        check_ammo("prio_ack", 7, 3, 2);
        wait_idle();

        // Timeout on launcher 2: no decrement, fault sticky, next grant to launcher 3.
        radar_2 = 1'b1; radar_3 = 1'b1;
        tick();
        check("to_sel", fire_sel, 2);
        repeat (15) tick();
        check("to_still_req", fire_req, 1);
        check("to_no_fault_yet", fault, 0);
        tick();
        check("to_req_drop", fire_req, 0);
        check("to_fault", fault, 1);
        check("to_busy", busy, 0);
        check_ammo("to", 7, 3, 2);
        tick();
        check("to_next_req", fire_req, 1);
        check("to_next_sel", fire_sel, 3);
        ack_once();
        radar_2 = 1'b0; radar_3 = 1'b0;
        check_ammo("to_ack", 7, 3, 1);
        wait_idle();
        check("fault_sticky", fault, 1);

        // Empty launcher: last rocket fired, then radar alone cannot grant.
        radar_3 = 1'b1;
        tick();
        check("empty_sel", fire_sel, 3);
        ack_once();
        check_ammo("empty", 7, 3, 0);
        fires = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fire_req) fires++;
        end
        check("empty_no_fire", fires, 0);
        check("empty_idle", busy, 0);
        radar_3 = 1'b0;

        // fire_ack outside GRANT and reload_sel=0 have no effect.
        ack_once();
        do_reload(2'd0, 5'd5);
        check_ammo("ignored", 7, 3, 0);
        check("ignored_busy", busy, 0);

        // Saturation at MAX_AMMO.
        do_reload(2'd1, 5'd18);
        check("sat_25", ammunition_1, 25);
        do_reload(2'd1, 5'd10);
        check("sat_29", ammunition_1, 29);
        do_reload(2'd1, 5'd31);
        check("sat_hold", ammunition_1, 29);

        // Asynchronous reset in the middle of GRANT.
        radar_1 = 1'b1;
        tick();
        check("rg_req", fire_req, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rg_fire_req", fire_req, 0);
        check("rg_fire_sel", fire_sel, 0);
        check("rg_busy", busy, 0);
        check("rg_fault", fault, 0);
        check_ammo("rg", 0, 0, 0);
        radar_1 = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        check("post_rst_req", fire_req, 0);
        check_ammo("post_rst", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
